// File: rtl/frac_pkg.sv
// Shared definitions for the signed-fraction multiplier/divider family:
// default fraction width and the divider's FSM state encoding.
package frac_pkg;

    // Default divisor/quotient width (sign plus FRAC_N-1 fraction bits).
    localparam int FRAC_N = 4;

    // Divider controller states.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CHK  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // True when two operand sign bits disagree, i.e. the quotient is negative.
    function automatic logic signs_differ(input logic a_neg, input logic b_neg);
        return a_neg ^ b_neg;
    endfunction

endpackage

// File: rtl/frac_abs.sv
// Two's-complement magnitude. The W-bit unsigned result has one more
// bit of magnitude range than the signed input, so the most negative
// input (-1.0) maps to 2^(W-1) without wrapping.
module frac_abs #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_mag,
    output logic         o_neg
);

    assign o_neg = i_val[W-1];
    assign o_mag = o_neg ? (-i_val) : i_val;

endmodule

// File: rtl/fraction_division.sv
// Sequential signed-fraction divider: (2N-1)-bit dividend / N-bit divisor,
// sign-magnitude restoring division, one quotient bit per clock.
// Optional build macro FRACDIV_SAT_EN: saturate the quotient on overflow
// instead of forcing it to zero.
module fraction_division
    import frac_pkg::*;
#(
    parameter int N = FRAC_N
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             St,
    input  logic [2*N-2:0]   Dividend,
    input  logic [N-1:0]     Divisor,
    output logic [N-1:0]     Quotient,
    output logic [2*N-2:0]   Remainder,
    output logic             V,
    output logic             Done
);

    localparam int DW = 2*N - 1;
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_INIT = CW'(N-1);
    localparam logic [N-1:0]  Q_MAX    = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  Q_MIN    = {1'b1, {(N-1){1'b0}}};

    // Registered state, operands and working values
    state_t          r_state;
    logic [DW-1:0]   r_dvd;
    logic [N-1:0]    r_dvs;
    logic            r_ovf;
    logic [N-2:0]    r_p;
    logic [N-2:0]    r_q;
    logic [CW-1:0]   r_cnt;

    // Registered outputs
    logic [N-1:0]    r_quot;
    logic [DW-1:0]   r_rem;
    logic            r_v;
    logic            r_done;

    // Combinational helpers
    logic [DW-1:0]   w_d;
    logic            w_dneg;
    logic [N-1:0]    w_m;
    logic            w_mneg;
    logic            w_ovf;
    logic [CW-1:0]   w_idx;
    logic [N-1:0]    w_shift;
    logic            w_ge;
    logic [N-2:0]    w_diff;
    logic [N-2:0]    w_next_p;
    logic [N-1:0]    w_qmag;
    logic [N-1:0]    w_quot_fix;
    logic [DW-1:0]   w_pext;
    logic [DW-1:0]   w_rem_fix;
    logic [N-1:0]    w_quot_ovf;

    frac_abs #(.W(DW)) u_abs_dvd (
        .i_val (r_dvd),
        .o_mag (w_d),
        .o_neg (w_dneg)
    );

    frac_abs #(.W(N)) u_abs_dvs (
        .i_val (r_dvs),
        .o_mag (w_m),
        .o_neg (w_mneg)
    );

    // Quotient must stay below 1.0: the top N bits of D must be smaller than M.
    assign w_ovf = (w_m == {N{1'b0}}) ||
                   ((w_d >> (N-1)) >= {{(DW-N){1'b0}}, w_m});

    // One restoring step: bring down the next dividend bit and trial-subtract.
    assign w_idx    = r_cnt - CNT_ONE;
    assign w_shift  = {r_p, w_d[w_idx]};
    assign w_ge     = (w_shift >= w_m);
    assign w_diff   = (N-1)'(w_shift - w_m);
    assign w_next_p = w_ge ? w_diff : w_shift[N-2:0];

    // Reapply signs: quotient by sign mismatch, remainder follows the dividend.
    assign w_qmag     = {1'b0, r_q};
    assign w_quot_fix = signs_differ(w_dneg, w_mneg) ? (-w_qmag) : w_qmag;
    assign w_pext     = {{(DW-N+1){1'b0}}, r_p};
    assign w_rem_fix  = w_dneg ? (-w_pext) : w_pext;

`ifdef FRACDIV_SAT_EN
    // A zero divisor has a clear sign bit, so divide-by-zero saturates by
    // the dividend sign alone (zero dividend counts as positive).
    assign w_quot_ovf = signs_differ(w_dneg, w_mneg) ? Q_MIN : Q_MAX;
`else
    assign w_quot_ovf = {N{1'b0}};
`endif

    assign Quotient  = r_quot;
    assign Remainder = r_rem;
    assign V         = r_v;
    assign Done      = r_done;

    // Controller FSM with operand capture, division datapath and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_dvd   <= {DW{1'b0}};
            r_dvs   <= {N{1'b0}};
            r_ovf   <= 1'b0;
            r_p     <= {(N-1){1'b0}};
            r_q     <= {(N-1){1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_quot  <= {N{1'b0}};
            r_rem   <= {DW{1'b0}};
            r_v     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (St) begin
                        r_dvd   <= Dividend;
                        r_dvs   <= Divisor;
                        r_state <= S_CHK;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CHK: begin
                    if (w_ovf) begin
                        // Overflow results are published here; the pass through
                        // S_FIX only times the Done pulse one edge later.
                        r_v     <= 1'b1;
                        r_quot  <= w_quot_ovf;
                        r_rem   <= r_dvd;
                        r_ovf   <= 1'b1;
                        r_state <= S_FIX;
                    end else begin
                        r_p     <= w_d[DW-2:N-1];
                        r_q     <= {(N-1){1'b0}};
                        r_cnt   <= CNT_INIT;
                        r_ovf   <= 1'b0;
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_p   <= w_next_p;
                    r_q   <= {r_q[N-3:0], w_ge};
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state <= S_FIX;
                    end else begin
                        r_state <= S_DIV;
                    end
                end
                S_FIX: begin
                    if (!r_ovf) begin
                        r_quot <= w_quot_fix;
                        r_rem  <= w_rem_fix;
                        r_v    <= 1'b0;
                    end else begin
                        r_v    <= 1'b1;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
